// File: rtl/scroll_sequencer_pkg.sv
// rtl/scroll_sequencer_pkg.sv - shared constants, state encoding and anode decode for the scroll sequencer
package scroll_sequencer_pkg;

   localparam int MSG_LEN    = 20;
   localparam int NUM_DIGITS = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Active-low one-hot: digit 0 is the leftmost position, anode bit 3.
   function automatic logic [3:0] digit_anode(input logic [1:0] digit);
      return ~(4'b1000 >> digit);
   endfunction

endpackage

// File: rtl/scroll_sequencer_mod_counter.sv
// rtl/scroll_sequencer_mod_counter.sv - modulo-N counter with enable, synchronous clear and terminal-count flag
module mod_counter #(
   parameter int MOD = 4,
   parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [W-1:0] count;

   assign tc = en && (count == W'(MOD - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/scroll_sequencer.sv
// rtl/scroll_sequencer.sv - scrolls a 20-position message across a 4-digit multiplexed display
module scroll_sequencer
   import scroll_sequencer_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int SCROLL_DIV  = 12500000,
   parameter int LOOP        = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   output logic [4:0] scrollingIndex,
   output logic [3:0] anode,
   output logic       busy,
   output logic       pass_done
);

   state_t     state;
   state_t     state_next;
   logic       run;
   logic       refresh_tc;
   logic       scroll_tc;
   logic       wrap;
   logic [1:0] digit;
   logic [4:0] window;
   logic [5:0] sum;
   logic [5:0] sum_mod;
   logic [4:0] index_next;
   logic [3:0] anode_s1;
   logic [3:0] anode_s1_next;

   assign run  = (state == ST_RUN);
   assign wrap = run && scroll_tc && (window == 5'(MSG_LEN - 1));

   mod_counter #(.MOD(REFRESH_DIV)) u_refresh (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .en  (1'b1),
      .tc  (refresh_tc)
   );

   // Held cleared outside RUN so every pass starts on a full scroll period.
   mod_counter #(.MOD(SCROLL_DIV)) u_scroll (
      .clk (clk),
      .rst (rst),
      .clr (!run),
      .en  (run),
      .tc  (scroll_tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (start && !stop) state_next = ST_RUN;
         ST_RUN:  if (stop || (wrap && (LOOP == 0))) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy          = run;
      sum           = {1'b0, window} + {4'b0000, digit};
      sum_mod       = (sum >= 6'(MSG_LEN)) ? sum - 6'(MSG_LEN) : sum;
      index_next    = run ? 5'(sum_mod) : 5'd0;
      anode_s1_next = run ? digit_anode(digit) : 4'b1111;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit <= 2'd0;
      end else if (refresh_tc) begin
         digit <= (digit == 2'(NUM_DIGITS - 1)) ? 2'd0 : digit + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         window <= 5'd0;
      end else if (scroll_tc) begin
         window <= (window == 5'(MSG_LEN - 1)) ? 5'd0 : window + 5'd1;
      end
   end

   // The extra anode stage lines the enables up with the pattern ROM output.
   always_ff @(posedge clk) begin
      if (rst) begin
         scrollingIndex <= 5'd0;
         anode_s1       <= 4'b1111;
         anode          <= 4'b1111;
         pass_done      <= 1'b0;
      end else begin
         scrollingIndex <= index_next;
         anode_s1       <= anode_s1_next;
         anode          <= anode_s1;
         pass_done      <= wrap;
      end
   end

endmodule

// File: tb/tb_scroll_sequencer.sv
// tb/tb_scroll_sequencer.sv - directed self-checking bench for scroll_sequencer in loop and single-pass modes
module tb_scroll_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic [4:0] idx_loop, idx_once;
   logic [3:0] anode_loop, anode_once;
   logic       busy_loop, busy_once;
   logic       pd_loop, pd_once;

   int vectors  = 0;
   int miscompares = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   scroll_sequencer #(.REFRESH_DIV(4), .SCROLL_DIV(32), .LOOP(1)) u_loop (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .stop           (stop),
      .scrollingIndex (idx_loop),
      .anode          (anode_loop),
      .busy           (busy_loop),
      .pass_done      (pd_loop)
   );

   scroll_sequencer #(.REFRESH_DIV(4), .SCROLL_DIV(32), .LOOP(0)) u_once (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .stop           (stop),
      .scrollingIndex (idx_once),
      .anode          (anode_once),
      .busy           (busy_once),
      .pass_done      (pd_once)
   );

   task automatic check(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   function automatic int onehot_n(input int d);
      logic [3:0] v;
      v = ~(4'b1000 >> d);
      return int'(v);
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cyc = 0;
      check("rst_anode", anode_loop, 4'b1111);
      check("rst_idx", idx_loop, 0);
      check("rst_busy", busy_loop, 0);
      check("rst_pd", pd_loop, 0);

      rst = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("start_busy", busy_loop, 1);
      check("start_idx", idx_loop, 0);
      for (int n = 2; n <= 16; n++) begin
         tick();
         check("seq_idx", idx_loop, (n - 1) / 4);
         check("seq_anode", anode_loop, (n == 2) ? 15 : onehot_n((n - 2) / 4));
      end

      run_to(618);
      check("w19_d2_idx", idx_loop, 1);
      run_to(640);
      check("pre_wrap_pd", pd_loop, 0);
      check("pre_wrap_busy_once", busy_once, 1);
      tick();
      check("wrap_pd_loop", pd_loop, 1);
      check("wrap_pd_once", pd_once, 1);
      check("wrap_busy_once", busy_once, 0);
      check("wrap_busy_loop", busy_loop, 1);
      check("wrap_idx19", idx_loop, 19);
      tick();
      check("post_wrap_pd_loop", pd_loop, 0);
      check("post_wrap_pd_once", pd_once, 0);
      check("post_wrap_idx", idx_loop, 0);
      check("once_anode_lag", anode_once, 4'b0111);
      tick();
      check("once_anode_idle", anode_once, 4'b1111);
      check("once_idx_idle", idx_once, 0);

      run_to(880);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_busy", busy_loop, 0);
      tick();
      check("stop_idx", idx_loop, 0);

      run_to(895);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_busy_loop", busy_loop, 1);
      check("restart_busy_once", busy_once, 1);
      for (int j = 1; j <= 16; j++) begin
         tick();
         check("restart_idx_loop", idx_loop, (j - 1) / 4);
         check("restart_idx_once", idx_once, (j - 1) / 4);
      end

      run_to(1130);
      check("pre_rst_busy", busy_loop, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_pd", pd_loop, 0);
      check("midrst_busy", busy_loop, 0);
      check("midrst_idx", idx_loop, 0);
      check("midrst_anode", anode_loop, 4'b1111);

      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("start_stop_busy_loop", busy_loop, 0);
      check("start_stop_busy_once", busy_once, 0);

      run_to(1146);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rst_restart_busy", busy_loop, 1);
      for (int j = 1; j <= 8; j++) begin
         tick();
         check("rst_restart_idx", idx_loop, (j - 1) / 4);
         check("rst_restart_anode", anode_loop, (j == 1) ? 15 : onehot_n((j - 2) / 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/scroll_sequencer.md
SCROLL_SEQUENCER -- requirements
Module: scroll_sequencer

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clocks per digit-multiplex slot; legal values are 2 or more.
REQ-002 Parameter SCROLL_DIV, default 12500000: clocks per scroll step; legal values are 2 or more.
REQ-003 Parameter LOOP, default 1: 1 = scroll continuously; 0 = stop after one full pass.
REQ-004 clk  in  1  system clock; all logic SHALL be on the rising edge of clk.
REQ-005 rst  in  1  reset; synchronous and active-high.
REQ-006 start  in  1  single-cycle pulse that begins scrolling from IDLE.
REQ-007 stop  in  1  single-cycle pulse that returns the block to IDLE.
REQ-008 scrollingIndex  out  5  registered message position for the downstream segment-pattern ROM, range 0..19.
REQ-009 anode  out  4  registered digit enables, active-low; bit 3 = leftmost digit.
REQ-010 busy  out  1  high while the state is RUN.
REQ-011 pass_done  out  1  single-cycle pulse when the window wraps from 19 to 0.

Function
REQ-012 The state machine SHALL have two states, IDLE and RUN.
REQ-013 IDLE -> RUN SHALL occur on start; RUN -> IDLE SHALL occur on stop, or on a window wrap when LOOP=0.
REQ-014 If start and stop are high in the same cycle, stop SHALL win; start while in RUN SHALL be ignored.
REQ-015 Refresh counter: counts 0..REFRESH_DIV-1 in both states; at the terminal count it wraps to 0 and digit (0..3, 0 = leftmost) advances, wrapping 3 -> 0.
REQ-016 Scroll counter: counts 0..SCROLL_DIV-1 only in RUN and is held at 0 in IDLE; at the terminal count it wraps and window advances, wrapping 19 -> 0.
REQ-017 On entry to RUN, the window and scroll counter SHALL be 0.
REQ-018 In RUN, each cycle: scrollingIndex <= (window + digit) mod 20. The sum SHALL be computed 6 bits wide and 20 subtracted when the sum is 20 or more.
REQ-019 In IDLE, scrollingIndex <= 0, which is a blank position.
REQ-020 anode SHALL lag scrollingIndex by exactly one cycle, matching the one-cycle registered latency of the downstream pattern ROM.
REQ-021 The anode pipeline: stage-1 <= active-low one-hot of digit (digit 0 -> 4'b0111, 3 -> 4'b1110), or 4'b1111 in IDLE; anode <= stage-1.
REQ-022 pass_done SHALL pulse for one cycle on the clock edge where the window changes 19 -> 0, in both LOOP modes.
REQ-023 With LOOP=0, that wrap SHALL also move the state to IDLE; window = 0 after the wrap.
REQ-024 A window step and a digit step in the same cycle SHALL both take effect; the next scrollingIndex SHALL use both new values.
REQ-025 A stop in the same cycle as a window wrap: pass_done SHALL still pulse and the state SHALL go to IDLE.

Reset
REQ-026 rst SHALL dominate all other inputs.
REQ-027 Next edge after rst: state = IDLE, both counters = 0, digit = 0, window = 0, scrollingIndex = 0, anode pipeline = 4'b1111, busy = 0, pass_done = 0.
REQ-028 rst asserted mid-RUN SHALL abort scrolling with no pass_done pulse.

Structure
REQ-029 A shared package SHALL hold MSG_LEN = 20, NUM_DIGITS = 4, and the IDLE/RUN state encoding.
REQ-030 One sub-module, mod_counter (parameterised modulus, enable, terminal-count output), SHALL be instantiated twice: once for refresh and once for scroll.

Verification (REFRESH_DIV=4, SCROLL_DIV=32)
REQ-031 Reset -> from the first cycle after rst: anode = 4'b1111, scrollingIndex = 0, busy = 0.
REQ-032 start at window 0, then hold 16 cycles -> scrollingIndex sequence 0,1,2,3 (4 cycles each); anode 4'b0111, 4'b1011, 4'b1101, 4'b1110, each one cycle after its index.
REQ-033 Run 19 scroll steps (window 19), digit 2 -> scrollingIndex = 1; at the next step: pass_done for 1 cycle, window = 0.
REQ-034 LOOP=0, run a full pass -> one pass_done pulse, busy falls on that same edge, anode returns to 4'b1111 two cycles later.
REQ-035 start and stop in the same cycle while in IDLE -> remains IDLE, busy = 0.
REQ-036 stop or rst mid-RUN at window 7 -> IDLE; a subsequent start restarts with window 0, scrollingIndex 0..3.
